// File: rtl/float_fmt_pkg.sv
// Half/single float field layout, canonical special encodings and operand classification.
package float_fmt_pkg;

  typedef enum logic [1:0] {CLS_ZERO, CLS_FINITE, CLS_INF, CLS_NAN} fp_class_e;

  // Result kind is resolved at unpack time and applied when the result is packed.
  typedef enum logic [2:0] {RES_NORM, RES_ONE, RES_INF, RES_ZERO, RES_NAN} res_kind_e;

  localparam int          HALF_EXP_BITS    = 5;
  localparam int          HALF_MANT_BITS   = 10;
  localparam int          HALF_BIAS        = 15;
  localparam logic [15:0] HALF_NAN         = 16'h7E00;
  localparam logic [15:0] HALF_INF         = 16'h7C00;
  localparam logic [15:0] HALF_ONE         = 16'h3C00;

  localparam int          SINGLE_EXP_BITS  = 8;
  localparam int          SINGLE_MANT_BITS = 23;
  localparam int          SINGLE_BIAS      = 127;
  localparam logic [31:0] SINGLE_NAN       = 32'h7FC0_0000;
  localparam logic [31:0] SINGLE_INF       = 32'h7F80_0000;
  localparam logic [31:0] SINGLE_ONE       = 32'h3F80_0000;

  // Subnormals classify as zero: they are flushed on input.
  function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic mant_zero);
    if (exp_zero) return CLS_ZERO;
    if (exp_ones) return mant_zero ? CLS_INF : CLS_NAN;
    return CLS_FINITE;
  endfunction

endpackage

// File: rtl/exp2_table_zero_to_one.sv
// 2^f for f in [0,1): table lookup of T[i], D[i] then linear interpolation, 2-cycle latency.
module exp2_table_zero_to_one
  import float_fmt_pkg::*;
#(
  parameter int BITS      = 16,
  parameter     PRECISION = "HALF",
  parameter int STEPS     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 valid_i,
  input  logic [BITS-((PRECISION == "SINGLE") ? SINGLE_EXP_BITS : HALF_EXP_BITS)+2:0] f_i,
  output logic                                 valid_o,
  output logic [BITS-((PRECISION == "SINGLE") ? SINGLE_EXP_BITS : HALF_EXP_BITS)+3:0] m_o
);

  localparam int EXP_BITS  = (PRECISION == "SINGLE") ? SINGLE_EXP_BITS : HALF_EXP_BITS;
  localparam int MANT_BITS = BITS - 1 - EXP_BITS;
  localparam int FRAC      = MANT_BITS + 4;
  localparam int TW        = FRAC + 1;
  localparam int LOG_STEPS = $clog2(STEPS);
  localparam int RW        = FRAC - LOG_STEPS;

  // One extra bit so T[STEPS] = 2.0 is representable when forming the last slope.
  function automatic logic [TW:0] exp2_fix(input int idx);
    real v;
    v = 2.0 ** (real'(idx) / real'(STEPS));
    return (TW + 1)'($rtoi(v * real'(1 << FRAC) + 0.5));
  endfunction

  logic [TW-1:0]   t_tab [STEPS];
  logic [FRAC-1:0] d_tab [STEPS];

  for (genvar g = 0; g < STEPS; g++) begin : g_tab
    localparam logic [TW:0] T_LO = exp2_fix(g);
    localparam logic [TW:0] T_HI = exp2_fix(g + 1);
    assign t_tab[g] = T_LO[TW-1:0];
    assign d_tab[g] = FRAC'(T_HI - T_LO);
  end

  logic [LOG_STEPS-1:0] idx;
  logic                 v2_q, v3_q;
  logic [TW-1:0]        t_q;
  logic [FRAC-1:0]      d_q;
  logic [RW-1:0]        r_q;
  logic [FRAC+RW-1:0]   prod;
  logic [FRAC-1:0]      interp;
  logic [TW-1:0]        m_q;
  logic                 unused_prod;

  assign idx         = f_i[FRAC-1 -: LOG_STEPS];
  assign prod        = (FRAC + RW)'(d_q) * (FRAC + RW)'(r_q);
  assign interp      = prod[FRAC+RW-1:RW];
  assign unused_prod = ^prod[RW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v2_q <= valid_i;
      v3_q <= v2_q;
    end
    t_q <= t_tab[idx];
    d_q <= d_tab[idx];
    r_q <= f_i[RW-1:0];
    m_q <= t_q + {1'b0, interp};
  end

  assign valid_o = v3_q;
  assign m_o     = m_q;

endmodule

// File: rtl/exp2_table.sv
// c = 2^a for half/single floats: split a into n + f, evaluate 2^f, repack with exponent n.
module exp2_table
  import float_fmt_pkg::*;
#(
  parameter int BITS      = 16,
  parameter     PRECISION = "HALF",
  parameter int STEPS     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [BITS-1:0] a,
  output logic            out_valid,
  output logic [BITS-1:0] c
);

  localparam bit IS_SINGLE = (PRECISION == "SINGLE");
  localparam int EXP_BITS  = IS_SINGLE ? SINGLE_EXP_BITS : HALF_EXP_BITS;
  localparam int MANT_BITS = IS_SINGLE ? SINGLE_MANT_BITS : HALF_MANT_BITS;
  localparam int BIAS      = IS_SINGLE ? SINGLE_BIAS : HALF_BIAS;
  localparam int FRAC      = MANT_BITS + 4;
  localparam int NW        = EXP_BITS + 1;
  localparam int WW        = FRAC + EXP_BITS;
  localparam int MAX_EXP   = (1 << EXP_BITS) - 1;
  localparam logic [BITS-1:0] C_NAN = IS_SINGLE ? BITS'(SINGLE_NAN) : BITS'(HALF_NAN);
  localparam logic [BITS-1:0] C_INF = IS_SINGLE ? BITS'(SINGLE_INF) : BITS'(HALF_INF);
  localparam logic [BITS-1:0] C_ONE = IS_SINGLE ? BITS'(SINGLE_ONE) : BITS'(HALF_ONE);

  logic                 a_sign;
  logic [EXP_BITS-1:0]  a_exp;
  logic [MANT_BITS-1:0] a_mant;
  fp_class_e            a_cls;
  int                   e_unb, sh;
  logic [WW-1:0]        mag;
  logic signed [WW:0]   fix;
  res_kind_e            s1_kind_d;
  logic [NW-1:0]        s1_n_d;
  logic [FRAC-1:0]      s1_f_d;

  assign a_sign = a[BITS-1];
  assign a_exp  = a[BITS-2 -: EXP_BITS];
  assign a_mant = a[MANT_BITS-1:0];
  assign a_cls  = fp_classify(a_exp == '0, &a_exp, a_mant == '0);

  // Two's-complement fixed point makes the integer field floor(a) for negatives too.
  always_comb begin
    e_unb = int'(a_exp) - BIAS;
    sh    = e_unb + (FRAC - MANT_BITS);
    if (sh >= 0) mag = WW'({1'b1, a_mant}) << sh;
    else         mag = WW'({1'b1, a_mant}) >> (-sh);
    fix    = a_sign ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    s1_n_d = fix[WW:FRAC];
    s1_f_d = fix[FRAC-1:0];
    s1_kind_d = RES_NORM;
    case (a_cls)
      CLS_ZERO: s1_kind_d = RES_ONE;
      CLS_NAN:  s1_kind_d = RES_NAN;
      CLS_INF:  s1_kind_d = a_sign ? RES_ZERO : RES_INF;
      default: begin
        if (e_unb >= EXP_BITS)  s1_kind_d = a_sign ? RES_ZERO : RES_INF;
        else if (e_unb < -FRAC) s1_kind_d = RES_ONE;
      end
    endcase
  end

  logic                 s1_valid_q;
  logic [FRAC-1:0]      s1_f_q;
  logic signed [NW-1:0] s1_n_q, n2_q, n3_q;
  res_kind_e            s1_kind_q, kind2_q, kind3_q;

  always_ff @(posedge clk) begin
    if (rst) s1_valid_q <= 1'b0;
    else     s1_valid_q <= in_valid;
    s1_f_q    <= s1_f_d;
    s1_n_q    <= s1_n_d;
    s1_kind_q <= s1_kind_d;
    n2_q      <= s1_n_q;
    kind2_q   <= s1_kind_q;
    n3_q      <= n2_q;
    kind3_q   <= kind2_q;
  end

  logic            m_valid;
  logic [FRAC:0]   m_val;
  logic            unused_m;

  exp2_table_zero_to_one #(
    .BITS      (BITS),
    .PRECISION (PRECISION),
    .STEPS     (STEPS)
  ) u_zero_to_one (
    .clk     (clk),
    .rst     (rst),
    .valid_i (s1_valid_q),
    .f_i     (s1_f_q),
    .valid_o (m_valid),
    .m_o     (m_val)
  );

  assign unused_m = ^{m_val[FRAC], m_val[FRAC-MANT_BITS-1:0]};

  int              exp_sum;
  logic [BITS-1:0] c_d;

  always_comb begin
    exp_sum = int'(n3_q) + BIAS;
    c_d     = {1'b0, exp_sum[EXP_BITS-1:0], m_val[FRAC-1 -: MANT_BITS]};
    case (kind3_q)
      RES_ONE:  c_d = C_ONE;
      RES_INF:  c_d = C_INF;
      RES_ZERO: c_d = '0;
      RES_NAN:  c_d = C_NAN;
      default: begin
        if (exp_sum >= MAX_EXP) c_d = C_INF;
        else if (exp_sum <= 0)  c_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      c         <= '0;
    end else begin
      out_valid <= m_valid;
      if (m_valid) c <= c_d;
    end
  end

endmodule

// File: tb/tb_exp2_table.sv
// Directed and streaming bench for exp2_table in HALF/16 steps and SINGLE/64 steps.
module tb_exp2_table;

  logic        clk, rst;
  logic        in_valid_h, out_valid_h;
  logic [15:0] a_h, c_h;
  logic        in_valid_s, out_valid_s;
  logic [31:0] a_s, c_s;
  int          checks = 0;
  int          errors = 0;

  exp2_table #(.BITS(16), .PRECISION("HALF"), .STEPS(16)) u_half (
    .clk(clk), .rst(rst), .in_valid(in_valid_h), .a(a_h),
    .out_valid(out_valid_h), .c(c_h)
  );

  exp2_table #(.BITS(32), .PRECISION("SINGLE"), .STEPS(64)) u_single (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .a(a_s),
    .out_valid(out_valid_s), .c(c_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Real-arithmetic reference: 2^a rounded to nearest half, with the range clamps.
  function automatic logic [15:0] ref_half(input logic [15:0] x);
    real v, nr, m;
    int  n, mant, e;
    e = int'(x[14:10]);
    if (e == 0) v = 0.0;
    else        v = (1.0 + real'(x[9:0]) / 1024.0) * (2.0 ** real'(e - 15));
    if (x[15]) v = -v;
    nr   = $floor(v);
    n    = $rtoi(nr);
    m    = 2.0 ** (v - nr);
    mant = $rtoi((m - 1.0) * 1024.0 + 0.5);
    if (n + 15 >= 31) return 16'h7C00;
    if (n + 15 <= 0)  return 16'h0000;
    return 16'((n + 15) * 1024 + mant);
  endfunction

  task automatic drive_half(input logic [15:0] av, output logic [15:0] cv,
                            output logic v3, output logic v4, output logic v5);
    @(negedge clk);
    in_valid_h = 1'b1;
    a_h        = av;
    @(posedge clk); #1;
    in_valid_h = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    v3 = out_valid_h;
    @(posedge clk); #1;
    v4 = out_valid_h;
    cv = c_h;
    @(posedge clk); #1;
    v5 = out_valid_h;
  endtask

  task automatic drive_single(input logic [31:0] av, output logic [31:0] cv,
                              output logic v3, output logic v4);
    @(negedge clk);
    in_valid_s = 1'b1;
    a_s        = av;
    @(posedge clk); #1;
    in_valid_s = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    v3 = out_valid_s;
    @(posedge clk); #1;
    v4 = out_valid_s;
    cv = c_s;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid_h = 1'b1;
    a_h = 16'h4200;
    in_valid_s = 1'b0;
    a_s = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid_h !== 1'b0) begin errors++; $display("FAIL reset_valid_h got %b want 0", out_valid_h); end
    checks++; if (c_h !== 16'h0) begin errors++; $display("FAIL reset_c_h got %h want 0000", c_h); end
    checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL reset_valid_s got %b want 0", out_valid_s); end
    checks++; if (c_s !== 32'h0) begin errors++; $display("FAIL reset_c_s got %h want 00000000", c_s); end
    @(negedge clk);
    rst = 1'b0;
    in_valid_h = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid_h !== 1'b0) begin
        errors++; $display("FAIL reset_ignored_input cyc %0d got %b want 0", i, out_valid_h);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] cv;
    logic        v3, v4, v5;
    logic [15:0] va [2] = '{16'h4200, 16'hBC00};
    logic [15:0] vc [2] = '{16'h4800, 16'h3800};
    for (int i = 0; i < 2; i++) begin
      drive_half(va[i], cv, v3, v4, v5);
      checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL basic_early a=%h got %b want 0", va[i], v3); end
      checks++; if (v4 !== 1'b1) begin errors++; $display("FAIL basic_latency a=%h got %b want 1", va[i], v4); end
      checks++; if (cv !== vc[i]) begin errors++; $display("FAIL basic_value a=%h got %h want %h", va[i], cv, vc[i]); end
      checks++; if (v5 !== 1'b0) begin errors++; $display("FAIL basic_pulse a=%h got %b want 0", va[i], v5); end
    end
  endtask

  task automatic test_fraction();
    logic [15:0] cv;
    logic        v3, v4, v5;
    int          d;
    logic [15:0] va [2] = '{16'h3800, 16'hB800};
    logic [15:0] vc [2] = '{16'h3DA8, 16'h39A8};
    for (int i = 0; i < 2; i++) begin
      drive_half(va[i], cv, v3, v4, v5);
      d = int'(cv) - int'(vc[i]);
      checks++; if (v4 !== 1'b1) begin errors++; $display("FAIL frac_latency a=%h got %b want 1", va[i], v4); end
      checks++; if (d > 1 || d < -1) begin errors++; $display("FAIL frac_value a=%h got %h want %h+-1", va[i], cv, vc[i]); end
    end
  endtask

  task automatic test_specials();
    logic [15:0] cv;
    logic        v3, v4, v5;
    logic [15:0] va [9] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E01,
                            16'h4C00, 16'hCB80, 16'hCB00, 16'hCB01};
    logic [15:0] vc [9] = '{16'h3C00, 16'h3C00, 16'h7C00, 16'h0000, 16'h7E00,
                            16'h7C00, 16'h0000, 16'h0400, 16'h0000};
    for (int i = 0; i < 9; i++) begin
      drive_half(va[i], cv, v3, v4, v5);
      checks++; if (v4 !== 1'b1) begin errors++; $display("FAIL special_latency a=%h got %b want 1", va[i], v4); end
      checks++; if (cv !== vc[i]) begin errors++; $display("FAIL special_value a=%h got %h want %h", va[i], cv, vc[i]); end
    end
    // Just below the overflow threshold must stay finite.
    drive_half(16'h4BFF, cv, v3, v4, v5);
    checks++;
    if (cv !== 16'h7BF5 && cv !== 16'h7BF4 && cv !== 16'h7BF6) begin
      errors++; $display("FAIL boundary_4bff got %h want 7bf5+-1", cv);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ba [6] = '{16'h7E01, 16'h4200, 16'hFC00, 16'h0000, 16'h7C00, 16'hBC00};
    logic [15:0] bc [6] = '{16'h7E00, 16'h4800, 16'h0000, 16'h3C00, 16'h7C00, 16'h3800};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid_h = (i < 6);
      if (i < 6) a_h = ba[i];
      @(posedge clk); #1;
      if (i >= 3 && i < 9) begin
        checks++;
        if (out_valid_h !== 1'b1) begin errors++; $display("FAIL b2b_valid slot %0d got %b want 1", i - 3, out_valid_h); end
        checks++;
        if (c_h !== bc[i-3]) begin errors++; $display("FAIL b2b_value slot %0d got %h want %h", i - 3, c_h, bc[i-3]); end
      end else begin
        checks++;
        if (out_valid_h !== 1'b0) begin errors++; $display("FAIL b2b_idle cyc %0d got %b want 0", i, out_valid_h); end
      end
    end
    in_valid_h = 1'b0;
  endtask

  task automatic test_stream();
    bit          vh [0:1599];
    logic [15:0] ah [0:1599];
    logic [15:0] exp_c;
    logic        exp_v;
    int          nval, d;
    nval = 0;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      @(negedge clk);
      vh[cyc] = (nval < 1000) && ($urandom_range(0, 99) < 70);
      ah[cyc] = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 20)), 10'($urandom)};
      in_valid_h = vh[cyc];
      a_h        = ah[cyc];
      if (vh[cyc]) nval++;
      @(posedge clk); #1;
      exp_v = (cyc >= 3) ? vh[cyc-3] : 1'b0;
      checks++;
      if (out_valid_h !== exp_v) begin
        errors++; $display("FAIL stream_valid cyc %0d got %b want %b", cyc, out_valid_h, exp_v);
      end
      if (exp_v) begin
        exp_c = ref_half(ah[cyc-3]);
        d = int'(c_h) - int'(exp_c);
        checks++;
        if (d > 1 || d < -1) begin
          errors++; $display("FAIL stream_value a=%h got %h want %h+-1", ah[cyc-3], c_h, exp_c);
        end
      end
    end
    in_valid_h = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] cv;
    logic        v3, v4, v5;
    logic [15:0] va [3] = '{16'h4200, 16'h3800, 16'hBC00};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid_h = 1'b1;
      a_h = va[i];
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst = 1'b1;
    a_h = 16'h4400;
    @(posedge clk); #1;
    checks++; if (out_valid_h !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid_h); end
    checks++; if (c_h !== 16'h0) begin errors++; $display("FAIL midrst_c got %h want 0000", c_h); end
    @(negedge clk);
    rst = 1'b0;
    in_valid_h = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid_h !== 1'b0 || c_h !== 16'h0) begin
        errors++; $display("FAIL midrst_drop cyc %0d got v=%b c=%h want v=0 c=0000", i, out_valid_h, c_h);
      end
    end
    drive_half(16'h4400, cv, v3, v4, v5);
    checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL midrst_early got %b want 0", v3); end
    checks++; if (v4 !== 1'b1) begin errors++; $display("FAIL midrst_latency got %b want 1", v4); end
    checks++; if (cv !== 16'h4C00) begin errors++; $display("FAIL midrst_value got %h want 4c00", cv); end
  endtask

  task automatic test_single();
    logic [31:0] cv;
    logic        v3, v4;
    int          d;
    drive_single(32'h4120_0000, cv, v3, v4);
    checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", v3); end
    checks++; if (v4 !== 1'b1) begin errors++; $display("FAIL single_latency got %b want 1", v4); end
    checks++; if (cv !== 32'h4480_0000) begin errors++; $display("FAIL single_ten got %h want 44800000", cv); end
    drive_single(32'h3F00_0000, cv, v3, v4);
    d = int'(cv) - int'(32'h3FB5_04F3);
    checks++; if (d > 2 || d < -2) begin errors++; $display("FAIL single_half got %h want 3fb504f3+-2", cv); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fraction();
    test_specials();
    test_back_to_back();
    test_stream();
    test_reset_mid();
    test_single();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
